// File: rtl/score_tracker.sv
// score_tracker
//   Score keeper on the consumer side of the cannon game's result bus.
//   result_valid, hit and start_new_game are synchronised (SYNC_STAGES flops)
//   and edge-detected. Each rising result edge seen while a game is running
//   counts one shot. The block tracks shots, hits, the current and best hit
//   streak, and the win/lose outcome, and emits a one-cycle event strobe per
//   counted shot.
//
//   Optional feature macro: SCORE_TRACKER_TIMEOUT_EN
//     When defined, a shot clock counts ena-qualified PLAY cycles. If
//     TIMEOUT_CYCLES pass with no result edge, a miss is counted with
//     event_timeout=1. When undefined, event_timeout is tied 0 and
//     TIMEOUT_CYCLES is ignored.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             enable; low freezes score state and discards edges
//   result_valid    level, shot resolved
//   hit             shot result, sampled with result_valid
//   target_x[4:0]   target column, sampled unsynchronised at event time
//   start_new_game  level, rising edge starts a new game
//   shots/hits      counters for the current game
//   streak          current consecutive hits
//   best_streak     longest streak in this game
//   last_target_x   target_x captured at the last result event
//   event_valid     one-cycle pulse per counted shot
//   event_hit       result of that shot
//   event_timeout   shot was a timeout miss
//   game_over, win  game finished / finished with hits >= WIN_HITS
module score_tracker #(
    parameter int unsigned SHOTS_PER_GAME = 8,
    parameter int unsigned WIN_HITS       = 5,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       result_valid,
    input  logic       hit,
    input  logic [4:0] target_x,
    input  logic       start_new_game,
    output logic [3:0] shots,
    output logic [3:0] hits,
    output logic [3:0] streak,
    output logic [3:0] best_streak,
    output logic [4:0] last_target_x,
    output logic       event_valid,
    output logic       event_hit,
    output logic       event_timeout,
    output logic       game_over,
    output logic       win
);

    if (SHOTS_PER_GAME == 0 || SHOTS_PER_GAME > 15 || WIN_HITS == 0 ||
        WIN_HITS > SHOTS_PER_GAME || SYNC_STAGES == 0 || SYNC_STAGES > 3 ||
        TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("score_tracker: parameter out of range");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_OVER} state_t;

    localparam logic [3:0] LP_SHOTS = 4'(SHOTS_PER_GAME);
    localparam logic [3:0] LP_WIN   = 4'(WIN_HITS);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_rv_sync;
    logic [SYNC_STAGES-1:0] r_hit_sync;
    logic [SYNC_STAGES-1:0] r_st_sync;
    logic                   r_rv_prev;
    logic                   r_st_prev;

    logic       w_rv_edge;
    logic       w_st_edge;
    logic       w_hit;
    logic       w_tmo;
    logic [3:0] w_shots_nx;
    logic [3:0] w_hits_nx;
    logic [3:0] w_streak_nx;

    // Synchronisers and edge detectors run regardless of ena so that a
    // level held across an ena=0 window does not produce a late edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rv_sync  <= '0;
            r_hit_sync <= '0;
            r_st_sync  <= '0;
            r_rv_prev  <= 1'b0;
            r_st_prev  <= 1'b0;
        end else begin
            r_rv_sync[0]  <= result_valid;
            r_hit_sync[0] <= hit;
            r_st_sync[0]  <= start_new_game;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_rv_sync[i]  <= r_rv_sync[i-1];
                r_hit_sync[i] <= r_hit_sync[i-1];
                r_st_sync[i]  <= r_st_sync[i-1];
            end
            r_rv_prev <= r_rv_sync[SYNC_STAGES-1];
            r_st_prev <= r_st_sync[SYNC_STAGES-1];
        end
    end

    assign w_rv_edge   = r_rv_sync[SYNC_STAGES-1] & ~r_rv_prev;
    assign w_st_edge   = r_st_sync[SYNC_STAGES-1] & ~r_st_prev;
    assign w_hit       = r_hit_sync[SYNC_STAGES-1];
    assign w_shots_nx  = shots + 4'd1;
    assign w_hits_nx   = hits + 4'd1;
    assign w_streak_nx = streak + 4'd1;

`ifdef SCORE_TRACKER_TIMEOUT_EN
    localparam int unsigned    LP_TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [LP_TW-1:0] LP_TMO_LAST = LP_TW'(TIMEOUT_CYCLES - 1);

    logic [LP_TW-1:0] r_tmr;

    // Shot clock: restarts on game start, outside PLAY, and on every event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (ena) begin
            if (w_st_edge || r_state != ST_PLAY || w_rv_edge || w_tmo)
                r_tmr <= '0;
            else
                r_tmr <= r_tmr + 1'b1;
        end
    end

    assign w_tmo = (r_tmr == LP_TMO_LAST);
`else
    assign w_tmo         = 1'b0;
    assign event_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            shots         <= '0;
            hits          <= '0;
            streak        <= '0;
            best_streak   <= '0;
            last_target_x <= '0;
            event_valid   <= 1'b0;
            event_hit     <= 1'b0;
`ifdef SCORE_TRACKER_TIMEOUT_EN
            event_timeout <= 1'b0;
`endif
            game_over     <= 1'b0;
            win           <= 1'b0;
        end else begin
            event_valid <= 1'b0;
            event_hit   <= 1'b0;
`ifdef SCORE_TRACKER_TIMEOUT_EN
            event_timeout <= 1'b0;
`endif
            if (ena) begin
                // A start edge outranks a coincident result edge.
                if (w_st_edge) begin
                    r_state       <= ST_PLAY;
                    shots         <= '0;
                    hits          <= '0;
                    streak        <= '0;
                    best_streak   <= '0;
                    last_target_x <= '0;
                    game_over     <= 1'b0;
                    win           <= 1'b0;
                end else begin
                    case (r_state)
                        ST_IDLE: ;
                        ST_PLAY: begin
                            if (w_rv_edge || w_tmo) begin
                                event_valid <= 1'b1;
                                event_hit   <= w_rv_edge & w_hit;
`ifdef SCORE_TRACKER_TIMEOUT_EN
                                event_timeout <= ~w_rv_edge;
`endif
                                shots <= w_shots_nx;
                                if (w_rv_edge)
                                    last_target_x <= target_x;
                                if (w_rv_edge && w_hit) begin
                                    hits   <= w_hits_nx;
                                    streak <= w_streak_nx;
                                    if (w_streak_nx > best_streak)
                                        best_streak <= w_streak_nx;
                                end else begin
                                    streak <= '0;
                                end
                                if ((w_rv_edge && w_hit && w_hits_nx == LP_WIN) ||
                                    w_shots_nx == LP_SHOTS)
                                    r_state <= ST_OVER;
                            end
                        end
                        ST_OVER: begin
                            // Flags follow one cycle after the final event.
                            game_over <= 1'b1;
                            win       <= (hits >= LP_WIN);
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
